// File: rtl/instr_encoder_if.sv
// Field-bundle input channel and encoded-word output channel of the encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [2:0]  funct3;
  logic        alt;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;

  // Producer of bundles and consumer of words.
  modport master (
    output in_valid, op, funct3, alt, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  // The encoder itself.
  modport slave (
    input  in_valid, op, funct3, alt, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: field bundles in, encoded words with their
// instruction-memory addresses out. Two-stage pipeline; illegal bundles are
// dropped in S1 and raise a sticky error flag.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  instr_encoder_if.slave        bus,
  output logic [15:0]           word_cnt,
  output logic                  err
);

  localparam logic [2:0] OpR      = 3'd0;
  localparam logic [2:0] OpIAlu   = 3'd1;
  localparam logic [2:0] OpLoad   = 3'd2;
  localparam logic [2:0] OpStore  = 3'd3;
  localparam logic [2:0] OpBranch = 3'd4;
  localparam logic [2:0] OpJal    = 3'd5;
  localparam logic [2:0] OpJalr   = 3'd6;

  // S1: captured fields plus legality verdict. Only imm[20:0] is ever encoded.
  logic        s1_valid_q;
  logic        s1_legal_q;
  logic [2:0]  s1_op_q;
  logic [2:0]  s1_f3_q;
  logic        s1_alt_q;
  logic [4:0]  s1_rd_q;
  logic [4:0]  s1_rs1_q;
  logic [4:0]  s1_rs2_q;
  logic [20:0] s1_imm_q;

  // S2: the word presented to the sink.
  logic        s2_valid_q;
  logic [31:0] s2_instr_q;
  logic [31:0] s2_addr_q;

  logic [15:0] word_cnt_q;
  logic        err_q;

  logic        in_legal;
  logic        imm12_ok;
  logic        imm13_ok;
  logic        imm21_ok;
  logic [31:0] enc;
  logic [6:0]  f7;
  logic        out_fire;
  logic        s2_free;
  logic        s1_to_s2;
  logic        s1_leave;
  logic        in_ready;
  logic        in_fire;
  logic [15:0] cnt_next;
  logic [31:0] addr_next;

  // An immediate fits N bits when all bits above N-1 replicate the sign bit.
  assign imm12_ok = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
  assign imm13_ok = (&bus.imm[31:12]) | ~(|bus.imm[31:12]);
  assign imm21_ok = (&bus.imm[31:20]) | ~(|bus.imm[31:20]);

  // Legality of the bundle currently offered on the input.
  always_comb begin
    in_legal = 1'b0;
    case (bus.op)
      OpR:      in_legal = 1'b1;
      OpIAlu:   in_legal = imm12_ok & ~(bus.alt & (bus.funct3 != 3'b101));
      OpLoad:   in_legal = imm12_ok & (bus.funct3 != 3'b011) & (bus.funct3 != 3'b110) &
                           (bus.funct3 != 3'b111);
      OpStore:  in_legal = imm12_ok & (bus.funct3 <= 3'b010);
      OpBranch: in_legal = imm13_ok & ~bus.imm[0] & (bus.funct3 != 3'b010) &
                           (bus.funct3 != 3'b011);
      OpJal:    in_legal = imm21_ok & ~bus.imm[0];
      OpJalr:   in_legal = imm12_ok & (bus.funct3 == 3'b000);
      default:  in_legal = 1'b0;
    endcase
  end

  // Encode the word held in S1.
  always_comb begin
    f7  = s1_alt_q ? 7'b0100000 : 7'b0000000;
    enc = '0;
    case (s1_op_q)
      OpR:      enc = {f7, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, 7'b0110011};
      OpIAlu: begin
        // Shifts carry funct7 above the 5-bit shift amount.
        if (s1_f3_q == 3'b001 || s1_f3_q == 3'b101) begin
          enc = {f7, s1_imm_q[4:0], s1_rs1_q, s1_f3_q, s1_rd_q, 7'b0010011};
        end else begin
          enc = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, 7'b0010011};
        end
      end
      OpLoad:   enc = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, 7'b0000011};
      OpStore:  enc = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0],
                       7'b0100011};
      OpBranch: enc = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                       s1_imm_q[4:1], s1_imm_q[11], 7'b1100011};
      OpJal:    enc = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                       s1_rd_q, 7'b1101111};
      OpJalr:   enc = {s1_imm_q[11:0], s1_rs1_q, 3'b000, s1_rd_q, 7'b1100111};
      default:  enc = '0;
    endcase
  end

  // Pipeline flow control.
  always_comb begin
    out_fire = s2_valid_q & bus.out_ready;
    s2_free  = ~s2_valid_q | bus.out_ready;
    s1_to_s2 = s1_valid_q & s1_legal_q & s2_free;
    // Illegal bundles vacate S1 unconditionally.
    s1_leave = s1_valid_q & (~s1_legal_q | s2_free);
    in_ready = rst_n & ~clear & (~s1_valid_q | s1_leave);
    in_fire  = bus.in_valid & in_ready;
    cnt_next = word_cnt_q + {15'd0, out_fire};
    // A word entering S2 is the cnt_next-th word since the last flush.
    addr_next = BASE_ADDR + {14'd0, cnt_next, 2'b00};
  end

  // S1 capture / drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_legal_q <= 1'b0;
      s1_op_q    <= '0;
      s1_f3_q    <= '0;
      s1_alt_q   <= 1'b0;
      s1_rd_q    <= '0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_imm_q   <= '0;
    end else if (clear) begin
      s1_valid_q <= 1'b0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      s1_legal_q <= in_legal;
      s1_op_q    <= bus.op;
      s1_f3_q    <= bus.funct3;
      s1_alt_q   <= bus.alt;
      s1_rd_q    <= bus.rd;
      s1_rs1_q   <= bus.rs1;
      s1_rs2_q   <= bus.rs2;
      s1_imm_q   <= bus.imm[20:0];
    end else if (s1_leave) begin
      s1_valid_q <= 1'b0;
    end
  end

  // S2 load / hold / drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_addr_q  <= BASE_ADDR;
    end else if (clear) begin
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_addr_q  <= BASE_ADDR;
    end else if (s1_to_s2) begin
      s2_valid_q <= 1'b1;
      s2_instr_q <= enc;
      s2_addr_q  <= addr_next;
    end else if (out_fire) begin
      s2_valid_q <= 1'b0;
    end
  end

  // Handoff counter and sticky illegal-bundle flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else if (clear) begin
      word_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      word_cnt_q <= cnt_next;
      if (s1_valid_q && !s1_legal_q) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_instr = s2_instr_q;
  assign bus.out_addr  = s2_addr_q;
  assign word_cnt      = word_cnt_q;
  assign err           = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus randomized traffic, with a
// reference model feeding a scoreboard that an independent monitor drains.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_1000;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } bundle_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] word_cnt;
  logic        err;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  logic        err_exp = 1'b0;
  logic        ill_pipe = 1'b0;
  logic [15:0] mon_cnt = '0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_instr = '0;
  logic [31:0] prev_addr = '0;

  instr_encoder_if bus ();

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .bus      (bus),
    .word_cnt (word_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned fld(input int unsigned v, input int lo, input int n);
    return (v >> lo) & ((32'd1 << n) - 32'd1);
  endfunction

  function automatic logic ref_legal(input bundle_t b);
    int s;
    logic in12, in13, in21, even;
    s    = $signed(b.imm);
    in12 = (s >= -2048) && (s <= 2047);
    in13 = (s >= -4096) && (s <= 4095);
    in21 = (s >= -1048576) && (s <= 1048575);
    even = (s % 2) == 0;
    case (b.op)
      3'd0:    return 1'b1;
      3'd1:    return in12 && !(b.alt && b.f3 != 3'd5);
      3'd2:    return in12 && !(b.f3 == 3'd3 || b.f3 == 3'd6 || b.f3 == 3'd7);
      3'd3:    return in12 && b.f3 <= 3'd2;
      3'd4:    return in13 && even && !(b.f3 == 3'd2 || b.f3 == 3'd3);
      3'd5:    return in21 && even;
      3'd6:    return in12 && b.f3 == 3'd0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_encode(input bundle_t b);
    int unsigned f7, im, rd, r1, r2, f3, w;
    f7 = b.alt ? 32 : 0;
    im = b.imm;
    rd = b.rd; r1 = b.rs1; r2 = b.rs2; f3 = b.f3;
    w  = 0;
    case (b.op)
      3'd0: w = 'h33 + rd * 128 + f3 * 4096 + r1 * 32768 + r2 * (1 << 20) + f7 * (1 << 25);
      3'd1: begin
        if (f3 == 1 || f3 == 5) w = 'h13 + rd * 128 + f3 * 4096 + r1 * 32768 +
                                    (f7 * 32 + fld(im, 0, 5)) * (1 << 20);
        else w = 'h13 + rd * 128 + f3 * 4096 + r1 * 32768 + fld(im, 0, 12) * (1 << 20);
      end
      3'd2: w = 'h03 + rd * 128 + f3 * 4096 + r1 * 32768 + fld(im, 0, 12) * (1 << 20);
      3'd3: w = 'h23 + fld(im, 0, 5) * 128 + f3 * 4096 + r1 * 32768 + r2 * (1 << 20) +
                fld(im, 5, 7) * (1 << 25);
      3'd4: w = 'h63 + fld(im, 11, 1) * 128 + fld(im, 1, 4) * 256 + f3 * 4096 + r1 * 32768 +
                r2 * (1 << 20) + fld(im, 5, 6) * (1 << 25) + fld(im, 12, 1) * (1 << 31);
      3'd5: w = 'h6F + rd * 128 + fld(im, 12, 8) * 4096 + fld(im, 11, 1) * (1 << 20) +
                fld(im, 1, 10) * (1 << 21) + fld(im, 20, 1) * (1 << 31);
      3'd6: w = 'h67 + rd * 128 + r1 * 32768 + fld(im, 0, 12) * (1 << 20);
      default: w = 0;
    endcase
    return w;
  endfunction

  function automatic bundle_t mk(input int op, input int f3, input int alt, input int rd,
                                 input int rs1, input int rs2, input int imm);
    bundle_t b;
    b.op = 3'(op); b.f3 = 3'(f3); b.alt = 1'(alt);
    b.rd = 5'(rd); b.rs1 = 5'(rs1); b.rs2 = 5'(rs2); b.imm = 32'(imm);
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    int r;
    r = int'($urandom_range(0, 15));
    b.op  = (r < 14) ? 3'(r % 7) : 3'd7;
    b.f3  = 3'($urandom_range(0, 7));
    b.alt = ($urandom_range(0, 3) == 0);
    b.rd  = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
    case ($urandom_range(0, 4))
      0: b.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
      1: b.imm = 32'(int'($urandom_range(0, 8191)) - 4096);
      2: b.imm = 32'(int'($urandom_range(0, 2097151)) - 1048576);
      3: b.imm = $urandom;
      default: b.imm = 32'(int'($urandom_range(0, 15)) - 8);
    endcase
    return b;
  endfunction

  // ---------------- input sampler: feeds scoreboard and err model ----------------
  always @(negedge clk) begin : sampler
    bundle_t b;
    logic acc;
    if (!rst_n) begin
      err_exp  = 1'b0;
      ill_pipe = 1'b0;
    end else begin
      check("err", 32'(err), 32'(err_exp));
      if (clear) begin
        check("in_ready_during_clear", 32'(bus.in_ready), 32'd0);
        err_exp  = 1'b0;
        ill_pipe = 1'b0;
      end else begin
        err_exp = err_exp | ill_pipe;
        acc = bus.in_valid && bus.in_ready;
        b.op = bus.op; b.f3 = bus.funct3; b.alt = bus.alt;
        b.rd = bus.rd; b.rs1 = bus.rs1; b.rs2 = bus.rs2; b.imm = bus.imm;
        ill_pipe = acc && !ref_legal(b);
        if (acc && ref_legal(b)) exp_q.push_back(ref_encode(b));
      end
    end
  end

  // ---------------- output monitor: pops and compares ----------------
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (!rst_n) begin
      exp_q.delete();
      mon_cnt    = '0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_instr", bus.out_instr, prev_instr);
        check("hold_addr", bus.out_addr, prev_addr);
      end
      if (clear) begin
        exp_q.delete();
        mon_cnt    = '0;
        stall_prev = 1'b0;
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_word: got %h at %h, expected no word", bus.out_instr,
                     bus.out_addr);
          end else begin
            tests--;
            e = exp_q.pop_front();
            check("sb_instr", bus.out_instr, e);
            check("sb_addr", bus.out_addr, BASE + 32'(mon_cnt) * 4);
            check("sb_word_cnt", 32'(word_cnt), 32'(mon_cnt));
          end
          mon_cnt = mon_cnt + 16'd1;
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        prev_instr = bus.out_instr;
        prev_addr  = bus.out_addr;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bundle_t b);
    bus.op = b.op; bus.funct3 = b.f3; bus.alt = b.alt;
    bus.rd = b.rd; bus.rs1 = b.rs1; bus.rs2 = b.rs2; bus.imm = b.imm;
  endtask

  task automatic send(input bundle_t b);
    int n;
    @(posedge clk); #1;
    drive(b);
    bus.in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        tests++; fails++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] ei, input logic [31:0] ea,
                            output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(bus.out_valid && bus.out_ready) && lat < 40);
    if (!(bus.out_valid && bus.out_ready)) begin
      tests++; fails++;
      $display("FAIL %s: no word within %0d cycles, expected one", name, lat);
    end else begin
      check({name, "_instr"}, bus.out_instr, ei);
      check({name, "_addr"}, bus.out_addr, ea);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_out_instr"}, bus.out_instr, 32'd0);
    check({tag, "_out_addr"}, bus.out_addr, BASE);
    check({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin
    bundle_t add_b, sub_b, b;
    int lat;
    int n;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    add_b = mk(0, 0, 0, 3, 1, 2, 0);
    sub_b = mk(0, 0, 1, 5, 6, 7, 0);

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

    // R-type and latency
    send(add_b); idle();
    expect_out("add", 32'h002081B3, BASE, lat);
    check("add_latency", 32'(lat), 32'd2);
    send(sub_b); idle();
    expect_out("sub", 32'h407302B3, BASE + 4, lat);

    // Immediates
    send(mk(1, 0, 0, 1, 0, 0, -1)); idle();
    expect_out("addi", 32'hFFF00093, BASE + 8, lat);
    send(mk(3, 2, 0, 0, 1, 2, 8)); idle();
    expect_out("sw", 32'h0020A423, BASE + 12, lat);
    send(mk(4, 0, 0, 0, 0, 0, -4)); idle();
    expect_out("beq", 32'hFE000EE3, BASE + 16, lat);

    // Illegal branch (odd offset) followed by a legal add
    send(mk(4, 0, 0, 0, 1, 2, 3));
    send(add_b); idle();
    expect_out("add_after_illegal", 32'h002081B3, BASE + 20, lat);
    check("err_after_illegal", 32'(err), 32'd1);
    @(negedge clk);
    check("word_cnt_after_illegal", 32'(word_cnt), 32'd6);

    // Backpressure: 4 words, sink stalled 3 cycles once the first word arrives
    @(posedge clk); #1 bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(mk(1, 0, 0, i + 1, 0, 0, i + 10));
        idle();
      end
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!bus.out_valid && n < 20);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
          if (k > 0) @(negedge clk);
          check("bp_in_ready_stalled", 32'(bus.in_ready), 32'd0);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    check("bp_word_cnt", 32'(word_cnt), 32'd10);
    check("bp_no_lost_words", 32'(exp_q.size()), 32'd0);

    // Clear with a bundle offered in the same cycle
    @(posedge clk); #1;
    drive(add_b); bus.in_valid = 1'b1; clear = 1'b1;
    @(negedge clk);
    check("clear_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    check("clear_out_valid", 32'(bus.out_valid), 32'd0);
    check("clear_out_instr", bus.out_instr, 32'd0);
    check("clear_out_addr", bus.out_addr, BASE);
    check("clear_word_cnt", 32'(word_cnt), 32'd0);
    check("clear_err", 32'(err), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("clear_not_accepted", 32'(bus.out_valid), 32'd0);
    end
    send(add_b); idle();
    expect_out("add_after_clear", 32'h002081B3, BASE, lat);

    // Reset asserted mid-stream
    @(posedge clk); #1;
    drive(add_b); bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0; bus.in_valid = 1'b0;
    #1 check_reset_outputs("midreset");
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_midreset", 32'(bus.in_ready), 32'd1);
    send(sub_b); idle();
    expect_out("sub_after_reset", 32'h407302B3, BASE, lat);

    // Randomized traffic with random backpressure and occasional clears
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      drive(rand_bundle());
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      clear         = ($urandom_range(0, 59) == 0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; clear = 1'b0;
    repeat (5) @(negedge clk);
    check("random_drained", 32'(exp_q.size()), 32'd0);

    // Counter wrap: 65535 handshakes, then two more
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    for (int i = 0; i < 65535; i++) send(mk(1, 0, 0, (i % 31) + 1, 0, 0, i % 2048));
    idle();
    repeat (4) @(negedge clk);
    check("preload_word_cnt", 32'(word_cnt), 32'h0000FFFF);
    b = mk(1, 0, 0, 9, 2, 0, 77);
    send(b); idle();
    expect_out("wrap_last", ref_encode(b), BASE + 32'h0003FFFC, lat);
    @(negedge clk);
    check("wrap_word_cnt", 32'(word_cnt), 32'd0);
    b = mk(1, 0, 0, 10, 3, 0, -5);
    send(b); idle();
    expect_out("wrap_first", ref_encode(b), BASE, lat);
    repeat (3) @(negedge clk);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: bench still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
